// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vend_dispense_ctrl                                         |
// | Description : Sequences one vend: drives the dispense motor until it     |
// |               acknowledges, then returns the requested change as a       |
// |               train of fixed-width coin-return pulses separated by fixed |
// |               low gaps. Signals completion with a one-cycle done pulse.  |
// |                                                                          |
// | Parameters  : PULSE_W  coin-return pulse width, clk cycles (1..15)       |
// |               GAP_W    low time after every coin pulse, cycles (1..15)   |
// |               TIMEOUT  motor watchdog limit, cycles (1..255)             |
// |                                                                          |
// | Ports       : clk        in   clock, rising edge                         |
// |               rst_n      in   asynchronous reset, active low             |
// |               vend       in   dispense request (sampled in IDLE only)    |
// |               change[1:0] in  coins to return (sampled in IDLE only)     |
// |               motor_ack  in   motor finished, level (sampled in DISP)    |
// |               fault_clr  in   leaves FAULT (sampled in FAULT only)       |
// |               motor_req  out  drive dispense motor (registered)          |
// |               coin_ret   out  one pulse per returned coin (registered)   |
// |               busy       out  controller not idle (registered)           |
// |               done       out  one-cycle normal-completion pulse (reg.)   |
// |               fault      out  motor watchdog expired (registered)        |
// |                                                                          |
// | Option      : define VEND_MOTOR_TIMEOUT_EN to add the motor watchdog and |
// |               the FAULT state. Without it DISP waits for the ack         |
// |               indefinitely and fault is tied low.                        |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module vend_dispense_ctrl #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 4,
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vend,
    input  logic [1:0] change,
    input  logic       motor_ack,
    input  logic       fault_clr,
    output logic       motor_req,
    output logic       coin_ret,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DISP    = 3'd1;
    localparam logic [2:0] S_CHG_ON  = 3'd2;
    localparam logic [2:0] S_CHG_GAP = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    // Phase timer is loaded with (width - 1) on entry and the phase ends
    // at the edge where it reads zero, giving exactly PULSE_W / GAP_W cycles.
    localparam logic [3:0] C_PULSE_LOAD = 4'(PULSE_W - 1);
    localparam logic [3:0] C_GAP_LOAD   = 4'(GAP_W - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [3:0] r_tmr;
    logic [3:0] w_tmr_nxt;
    logic       w_done_nxt;

    logic       r_motor_req;
    logic       r_coin_ret;
    logic       r_busy;
    logic       r_done;

`ifdef VEND_MOTOR_TIMEOUT_EN
    localparam logic [7:0] C_WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wd;
    logic [7:0] w_wd_nxt;
    logic       r_fault;
`else
    // Without the watchdog these inputs/parameters have no function.
    logic [8:0] w_unused_cfg;
    assign w_unused_cfg = {fault_clr, 8'(TIMEOUT)};
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = r_tmr;
        w_done_nxt  = 1'b0;
`ifdef VEND_MOTOR_TIMEOUT_EN
        w_wd_nxt    = r_wd;
`endif

        case (r_state)
            S_IDLE: begin
                if (vend) begin
                    w_state_nxt = S_DISP;
                    w_cnt_nxt   = change;
                    w_tmr_nxt   = 4'd0;
`ifdef VEND_MOTOR_TIMEOUT_EN
                    w_wd_nxt    = 8'd0;
`endif
                end else if (change != 2'd0) begin
                    w_state_nxt = S_CHG_ON;
                    w_cnt_nxt   = change;
                    w_tmr_nxt   = C_PULSE_LOAD;
                end
            end

            S_DISP: begin
                // An ack already present on entry is taken at the first
                // DISP edge; it also wins over a coincident watchdog expiry.
                if (motor_ack) begin
                    if (r_cnt != 2'd0) begin
                        w_state_nxt = S_CHG_ON;
                        w_tmr_nxt   = C_PULSE_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tmr_nxt   = 4'd0;
                        w_done_nxt  = 1'b1;
                    end
                end
`ifdef VEND_MOTOR_TIMEOUT_EN
                else if (r_wd == C_WD_LAST) begin
                    w_state_nxt = S_FAULT;
                    w_cnt_nxt   = 2'd0;
                    w_tmr_nxt   = 4'd0;
                end else begin
                    w_wd_nxt = r_wd + 8'd1;
                end
`endif
            end

            S_CHG_ON: begin
                if (r_tmr == 4'd0) begin
                    w_state_nxt = S_CHG_GAP;
                    w_tmr_nxt   = C_GAP_LOAD;
                    if (r_cnt != 2'd0) begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - 4'd1;
                end
            end

            S_CHG_GAP: begin
                // The gap is served after the final coin as well, so the
                // coin mechanism always sees a full low time before reuse.
                if (r_tmr == 4'd0) begin
                    if (r_cnt != 2'd0) begin
                        w_state_nxt = S_CHG_ON;
                        w_tmr_nxt   = C_PULSE_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tmr_nxt   = 4'd0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - 4'd1;
                end
            end

            S_FAULT: begin
`ifdef VEND_MOTOR_TIMEOUT_EN
                // Fault exit is not a normal completion: no done pulse.
                if (fault_clr) begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = 4'd0;
                end
`else
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = 4'd0;
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 2'd0;
                w_tmr_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next
    // state so they change on the same edge as the state itself while
    // staying free of any input-to-output combinational path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_tmr       <= 4'd0;
            r_motor_req <= 1'b0;
            r_coin_ret  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tmr       <= w_tmr_nxt;
            r_motor_req <= (w_state_nxt == S_DISP);
            r_coin_ret  <= (w_state_nxt == S_CHG_ON);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
        end
    end

`ifdef VEND_MOTOR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd    <= 8'd0;
            r_fault <= 1'b0;
        end else begin
            r_wd    <= w_wd_nxt;
            r_fault <= (w_state_nxt == S_FAULT);
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign motor_req = r_motor_req;
    assign coin_ret  = r_coin_ret;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vend_dispense_ctrl                                      |
// | Description : Self-checking bench for vend_dispense_ctrl. Each issued    |
// |               vend/change request pushes its expected outcome (motor     |
// |               cycles, coin pulses, busy length) into a scoreboard; an    |
// |               independent monitor measures the output waveforms and      |
// |               compares on every done pulse.                              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vend_dispense_ctrl;

    localparam int PULSE_W = 4;
    localparam int GAP_W   = 4;
    localparam int TIMEOUT = 10;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       vend      = 1'b0;
    logic [1:0] change    = 2'd0;
    logic       motor_ack = 1'b0;
    logic       fault_clr = 1'b0;
    logic       motor_req;
    logic       coin_ret;
    logic       busy;
    logic       done;
    logic       fault;

    typedef struct {
        int motor;
        int pulses;
        int busy_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    vend_dispense_ctrl #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vend      (vend),
        .change    (change),
        .motor_ack (motor_ack),
        .fault_clr (fault_clr),
        .motor_req (motor_req),
        .coin_ret  (coin_ret),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: measures each transaction from the outputs alone.
    // ------------------------------------------------------------------
    int   acc_busy   = 0;
    int   acc_motor  = 0;
    int   acc_pulses = 0;
    int   run_len    = 0;
    int   gap_len    = 0;
    logic in_gap     = 1'b0;
    logic prev_coin  = 1'b0;
    logic prev_done  = 1'b0;
    exp_t got;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_busy = 0; acc_motor = 0; acc_pulses = 0;
            run_len = 0; gap_len = 0; in_gap = 1'b0;
            prev_coin = 1'b0; prev_done = 1'b0;
        end else begin
            if (done) chk("done_single_cycle", int'(prev_done), 0);
            if (busy) begin
                acc_busy++;
                if (motor_req) acc_motor++;
            end
            if (coin_ret && !prev_coin) begin
                if (in_gap) chk("gap_len", gap_len, GAP_W);
                in_gap = 1'b0;
                acc_pulses++;
                run_len = 0;
            end
            if (coin_ret) run_len++;
            if (!coin_ret && prev_coin) begin
                chk("pulse_len", run_len, PULSE_W);
                in_gap  = 1'b1;
                gap_len = 0;
            end
            if (busy && !coin_ret && in_gap) gap_len++;
            if (done) begin
                chk("busy_with_done", int'(busy), 0);
                chk("fault_with_done", int'(fault), 0);
                if (in_gap) chk("last_gap_len", gap_len, GAP_W);
                chk("sb_depth_at_done", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    chk("motor_cycles", acc_motor, got.motor);
                    chk("coin_pulses", acc_pulses, got.pulses);
                    chk("busy_cycles", acc_busy, got.busy_cyc);
                end
            end
            if (!busy) begin
                acc_busy = 0; acc_motor = 0; acc_pulses = 0;
                run_len = 0; gap_len = 0; in_gap = 1'b0;
            end
            prev_coin = coin_ret;
            prev_done = done;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus. Expected results come from the behavioural rules:
    //   motor cycles = ack delay (an ack present on entry costs 1 cycle),
    //   each coin    = PULSE_W high + GAP_W low,
    //   busy length  = motor cycles + coins * (PULSE_W + GAP_W).
    // d = number of edges after the request edge at which ack is raised.
    // ------------------------------------------------------------------
    task automatic run_txn(input bit v, input int c, input int d, input int hold, input bit noise);
        exp_t e;
        int   motor;
        int   busy_len;
        int   ack_rel;
        motor    = v ? ((d == 0) ? 1 : d) : 0;
        busy_len = motor + c * (PULSE_W + GAP_W);
        ack_rel  = v ? (motor + 1 + hold) : -1;
        e.motor    = motor;
        e.pulses   = c;
        e.busy_cyc = busy_len;

        @(posedge clk); #1;
        vend   = v;
        change = 2'(c);
        if (v && d == 0) motor_ack = 1'b1;
        sb_q.push_back(e);

        for (int j = 1; j <= busy_len + 2; j++) begin
            @(posedge clk); #1;
            vend      = 1'b0;
            change    = 2'd0;
            fault_clr = 1'b0;
            if (!v) motor_ack = 1'b0;
            if (v && d > 0 && j == d) motor_ack = 1'b1;
            if (v && j == ack_rel) motor_ack = 1'b0;
            // Inputs that must be ignored while the controller is busy.
            if (noise && j <= busy_len - 1) begin
                vend      = 1'($urandom);
                change    = 2'($urandom);
                fault_clr = 1'($urandom);
                if (!v) motor_ack = 1'($urandom);
            end
        end
        motor_ack = 1'b0;
        @(negedge clk);
        chk("idle_after_txn", int'(busy), 0);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    int n_act;
    int n_mot;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_motor_req", int'(motor_req), 0);
        chk("rst_coin_ret", int'(coin_ret), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault", int'(fault), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed cases
        run_txn(1'b1, 0, 3, 0, 1'b0);   // vend only, ack after 3
        run_txn(1'b1, 2, 2, 0, 1'b0);   // vend with two coins
        run_txn(1'b0, 3, 0, 0, 1'b1);   // change only, ignored noise
        run_txn(1'b1, 1, 0, 2, 1'b0);   // ack already high at entry, held long
        run_txn(1'b1, 3, 8, 3, 1'b1);   // long ack wait, max change

        // Randomized cases
        for (int t = 0; t < 20; t++) begin
            bit v;
            int c;
            v = 1'($urandom);
            c = int'($urandom % 4);
            if (!v && c == 0) c = 1;
            run_txn(v, c, int'($urandom % 9), (c != 0) ? int'($urandom % 4) : 0, 1'($urandom));
            repeat (int'($urandom % 3)) @(posedge clk);
        end

        // Reset in the middle of a coin pulse
        @(posedge clk); #1 change = 2'd2;
        @(posedge clk); #1 change = 2'd0;
        @(posedge clk); #3;
        chk("coin_before_rst", int'(coin_ret), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_coin_ret", int'(coin_ret), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_motor_req", int'(motor_req), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        n_act = 0;
        for (int k = 0; k < 2 * (PULSE_W + GAP_W) + 4; k++) begin
            @(negedge clk);
            n_act += int'(coin_ret | busy);
        end
        chk("no_activity_after_rst", n_act, 0);

        // Post-reset controller must still work normally
        run_txn(1'b1, 1, 2, 0, 1'b0);

`ifdef VEND_MOTOR_TIMEOUT_EN
        // Motor never acknowledges
        @(posedge clk); #1 vend = 1'b1; change = 2'd2;
        @(posedge clk); #1 vend = 1'b0; change = 2'd0;
        n_mot = 0;
        n_act = 0;
        for (int k = 0; k < TIMEOUT + 6; k++) begin
            @(negedge clk);
            n_mot += int'(motor_req);
            n_act += int'(coin_ret);
        end
        chk("wd_motor_cycles", n_mot, TIMEOUT);
        chk("wd_no_coins", n_act, 0);
        chk("wd_fault", int'(fault), 1);
        chk("wd_busy", int'(busy), 1);
        @(posedge clk); #1 fault_clr = 1'b1;
        @(posedge clk); #1 fault_clr = 1'b0;
        @(negedge clk);
        chk("clr_fault", int'(fault), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_done", int'(done), 0);
        @(negedge clk);
        chk("clr_done_next", int'(done), 0);
        run_txn(1'b1, 1, 1, 0, 1'b0);
`else
        n_mot = 0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
